// File: rtl/dcache_port_requester.sv
// rtl/dcache_port_requester.sv - Initiator side of the L1 dcache request port
//
// Purpose: turns a valid/ready load/store command stream into the dcache
// index-phase / tag-phase / rvalid sequence, one transaction in flight, and
// returns a single response (data or error) per command.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o     command handshake
//   cmd_we_i, cmd_addr_i, cmd_wdata_i, cmd_be_i, cmd_size_i   command payload
//   kill_i                        abort the pending load before its tag phase
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_rdata_o, rsp_err_o        load data (0 for stores), timeout/killed flag
//   req_port_o / req_port_i       dcache request port (to / from the cache)

package dcache_port_pkg;
  localparam int unsigned IDX_W  = 12;
  localparam int unsigned TAG_W  = 44;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef struct packed {
    logic [IDX_W-1:0]  address_index;
    logic [TAG_W-1:0]  address_tag;
    logic [DATA_W-1:0] data_wdata;
    logic              data_req;
    logic              data_we;
    logic [BE_W-1:0]   data_be;
    logic [1:0]        data_size;
    logic              kill_req;
    logic              tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic              data_gnt;
    logic              data_rvalid;
    logic [DATA_W-1:0] data_rdata;
  } dcache_req_o_t;
endpackage

module dcache_port_requester #(
  parameter int unsigned IDX_W  = dcache_port_pkg::IDX_W,
  parameter int unsigned TAG_W  = dcache_port_pkg::TAG_W,
  parameter int unsigned DATA_W = dcache_port_pkg::DATA_W,
  parameter int unsigned BE_W   = DATA_W / 8,
  parameter int unsigned TMO    = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic                          cmd_we_i,
  input  logic [IDX_W+TAG_W-1:0]        cmd_addr_i,
  input  logic [DATA_W-1:0]             cmd_wdata_i,
  input  logic [BE_W-1:0]               cmd_be_i,
  input  logic [1:0]                    cmd_size_i,
  input  logic                          kill_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [DATA_W-1:0]             rsp_rdata_o,
  output logic                          rsp_err_o,
  output dcache_port_pkg::dcache_req_i_t req_port_o,
  input  dcache_port_pkg::dcache_req_o_t req_port_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_TAG,
    S_WAIT,
    S_RSP
  } state_e;

  // With TMO=0 the counter is kept as a single constant-zero bit.
  localparam int unsigned CNT_W = (TMO > 0) ? $clog2(TMO + 1) : 1;

  state_e             state_q;
  logic               cmd_ready_q;
  logic               data_req_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic               rsp_err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  // Holding register: the only source of the request-port payload.
  logic [IDX_W-1:0]   idx_q;
  logic [TAG_W-1:0]   tag_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [BE_W-1:0]    be_q;
  logic [1:0]         size_q;
  logic               we_q;

  logic gnt;
  logic rvalid;
  logic tmo_hit;
  logic wait_tmo;

  assign gnt    = req_port_i.data_gnt;
  assign rvalid = req_port_i.data_rvalid;

  // Fires in the last allowed cycle so the request is held for exactly TMO cycles.
  assign tmo_hit  = (TMO != 0) && (cnt_q == CNT_W'(TMO - 1));
  // A late rvalid in the timeout cycle still wins; no kill is needed then.
  assign wait_tmo = (state_q == S_WAIT) && !rvalid && tmo_hit;

  always_comb begin
    cnt_d = cnt_q;
    if (TMO == 0) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(TMO)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      data_req_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      tag_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      size_q      <= '0;
      we_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            idx_q       <= cmd_addr_i[IDX_W-1:0];
            tag_q       <= cmd_addr_i[IDX_W+TAG_W-1:IDX_W];
            wdata_q     <= cmd_wdata_i;
            be_q        <= cmd_be_i;
            size_q      <= cmd_size_i;
            we_q        <= cmd_we_i;
            cmd_ready_q <= 1'b0;
            data_req_q  <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_REQ;
          end
        end

        S_REQ: begin
          // A grant takes priority; an rvalid in the same cycle belongs to no load.
          if (gnt) begin
            data_req_q <= 1'b0;
            cnt_q      <= '0;
            if (we_q) begin
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b0;
              state_q     <= S_RSP;
            end else begin
              state_q <= S_TAG;
            end
          end else if ((kill_i && !we_q) || tmo_hit) begin
            // Withdrawing an ungranted request is legal; nothing is owed.
            data_req_q  <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= S_RSP;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_TAG: begin
          cnt_q <= '0;
          if (kill_i) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= S_RSP;
          end else begin
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (rvalid) begin
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= req_port_i.data_rdata;
            rsp_err_q   <= 1'b0;
            state_q     <= S_RSP;
          end else if (tmo_hit) begin
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= S_RSP;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
          data_req_q  <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  // tag_valid/kill_req must react to kill_i within the tag cycle itself, so
  // they are decoded from the registered state rather than registered again.
  always_comb begin
    req_port_o               = '0;
    req_port_o.address_index = idx_q;
    req_port_o.address_tag   = tag_q;
    req_port_o.data_wdata    = wdata_q;
    req_port_o.data_we       = we_q;
    req_port_o.data_be       = be_q;
    req_port_o.data_size     = size_q;
    req_port_o.data_req      = data_req_q;
    req_port_o.tag_valid     = (state_q == S_TAG) && !kill_i;
    req_port_o.kill_req      = ((state_q == S_TAG) && kill_i) || wait_tmo;
  end

endmodule

// File: tb/tb_dcache_port_requester.sv
// tb/tb_dcache_port_requester.sv - Directed self-checking bench for dcache_port_requester
module tb_dcache_port_requester;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [55:0] cmd_addr_i = '0;
  logic [63:0] cmd_wdata_i = '0;
  logic [7:0]  cmd_be_i = '0;
  logic [1:0]  cmd_size_i = '0;
  logic        kill_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;
  dcache_port_pkg::dcache_req_i_t req_port_o;
  dcache_port_pkg::dcache_req_o_t req_port_i = '0;

  int n_checks = 0;
  int n_fail   = 0;

  dcache_port_requester #(.TMO(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_be_i(cmd_be_i),
    .cmd_size_i(cmd_size_i), .kill_i(kill_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .req_port_o(req_port_o), .req_port_i(req_port_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a command in IDLE, steps one edge so the DUT is in REQ, withdraws it.
  task automatic issue(input logic we, input logic [55:0] addr, input logic [63:0] wd,
                       input logic [7:0] be);
    cmd_we_i    = we;
    cmd_addr_i  = addr;
    cmd_wdata_i = wd;
    cmd_be_i    = be;
    cmd_size_i  = 2'd3;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_rdata", rsp_rdata_o, 0);
    check("rst_rsp_err", rsp_err_o, 0);
    check("rst_req_port", req_port_o, 0);
    rst_ni = 1'b1;
    tick();

    // 1: load, gnt on 2nd REQ cycle, rvalid 4 cycles after tag
    check("t1_idle_ready", cmd_ready_o, 1);
    issue(1'b0, 56'h0000_1234_5008, 64'h0, 8'hFF);
    check("t1_req1_data_req", req_port_o.data_req, 1);
    check("t1_req1_index", req_port_o.address_index, 12'h008);
    check("t1_req1_cmd_ready", cmd_ready_o, 0);
    tick();
    req_port_i.data_gnt    = 1'b1;
    req_port_i.data_rvalid = 1'b1;   // same-cycle rvalid must be ignored
    req_port_i.data_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
    check("t1_req2_data_req", req_port_o.data_req, 1);
    tick();
    req_port_i = '0;
    check("t1_tag_valid", req_port_o.tag_valid, 1);
    check("t1_tag_value", req_port_o.address_tag, 44'h0000_0012_345);
    check("t1_tag_data_req", req_port_o.data_req, 0);
    check("t1_tag_kill", req_port_o.kill_req, 0);
    tick();
    check("t1_wait_tag_valid", req_port_o.tag_valid, 0);
    tick();
    tick();
    tick();
    req_port_i.data_rvalid = 1'b1;
    req_port_i.data_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
    check("t1_wait_rsp_valid", rsp_valid_o, 0);
    tick();
    req_port_i = '0;
    check("t1_rsp_valid", rsp_valid_o, 1);
    check("t1_rsp_rdata", rsp_rdata_o, 64'hDEAD_BEEF_0BAD_F00D);
    check("t1_rsp_err", rsp_err_o, 0);
    tick();
    check("t1_back_idle_valid", rsp_valid_o, 0);
    check("t1_back_idle_ready", cmd_ready_o, 1);

    // 2: store, gnt immediate
    issue(1'b1, 56'h00_ABCD_EF01_2345, 64'h1122_3344_5566_7788, 8'h0F);
    req_port_i.data_gnt = 1'b1;
    check("t2_req_we", req_port_o.data_we, 1);
    check("t2_req_be", req_port_o.data_be, 8'h0F);
    check("t2_req_wdata", req_port_o.data_wdata, 64'h1122_3344_5566_7788);
    check("t2_req_tag_valid", req_port_o.tag_valid, 0);
    tick();
    req_port_i = '0;
    check("t2_rsp_valid", rsp_valid_o, 1);
    check("t2_rsp_rdata", rsp_rdata_o, 0);
    check("t2_rsp_err", rsp_err_o, 0);
    check("t2_rsp_tag_valid", req_port_o.tag_valid, 0);
    tick();
    check("t2_idle_ready", cmd_ready_o, 1);

    // 3: load killed in the tag cycle
    issue(1'b0, 56'h00_0000_0777_7010, 64'h0, 8'hFF);
    req_port_i.data_gnt = 1'b1;
    tick();
    req_port_i = '0;
    kill_i = 1'b1;
    #1;
    check("t3_kill_req", req_port_o.kill_req, 1);
    check("t3_tag_valid", req_port_o.tag_valid, 0);
    tick();
    kill_i = 1'b0;
    req_port_i.data_rvalid = 1'b1;
    req_port_i.data_rdata  = 64'h5555_5555_5555_5555;
    check("t3_rsp_valid", rsp_valid_o, 1);
    check("t3_rsp_err", rsp_err_o, 1);
    check("t3_rsp_rdata", rsp_rdata_o, 0);
    tick();
    check("t3_idle_rdata", rsp_rdata_o, 0);
    check("t3_idle_ready", cmd_ready_o, 1);
    tick();
    req_port_i = '0;
    check("t3_late_rvalid_no_rsp", rsp_valid_o, 0);

    // 4: no grant, timeout after 8 REQ cycles
    issue(1'b0, 56'h00_0000_0000_0040, 64'h0, 8'hFF);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("t4_data_req_c%0d", k), req_port_o.data_req, 1);
      tick();
    end
    check("t4_data_req_dropped", req_port_o.data_req, 0);
    check("t4_rsp_valid", rsp_valid_o, 1);
    check("t4_rsp_err", rsp_err_o, 1);
    tick();
    check("t4_idle_ready", cmd_ready_o, 1);

    // 5: response back-pressure, next command waiting
    rsp_ready_i = 1'b0;
    issue(1'b0, 56'h00_0000_0000_0100, 64'h0, 8'hFF);
    req_port_i.data_gnt = 1'b1;
    tick();
    req_port_i = '0;
    tick();
    req_port_i.data_rvalid = 1'b1;
    req_port_i.data_rdata  = 64'hCAFE_F00D_1234_5678;
    tick();
    req_port_i = '0;
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b1;
    cmd_addr_i  = 56'h00_0000_0000_00F0;
    cmd_wdata_i = 64'hA5A5_A5A5_A5A5_A5A5;
    cmd_be_i    = 8'hFF;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("t5_hold_valid_c%0d", k), rsp_valid_o, 1);
      check($sformatf("t5_hold_rdata_c%0d", k), rsp_rdata_o, 64'hCAFE_F00D_1234_5678);
      check($sformatf("t5_hold_ready_c%0d", k), cmd_ready_o, 0);
      tick();
    end
    rsp_ready_i = 1'b1;
    check("t5_last_valid", rsp_valid_o, 1);
    tick();
    check("t5_after_hs_valid", rsp_valid_o, 0);
    check("t5_after_hs_ready", cmd_ready_o, 1);
    tick();
    cmd_valid_i = 1'b0;
    check("t5_next_req", req_port_o.data_req, 1);
    check("t5_next_index", req_port_o.address_index, 12'h0F0);
    req_port_i.data_gnt = 1'b1;
    tick();
    req_port_i = '0;
    check("t5_next_rsp_valid", rsp_valid_o, 1);
    tick();

    // 6: reset while in WAIT, then a fresh load
    issue(1'b0, 56'h00_0000_0ABC_D123, 64'h0, 8'hFF);
    req_port_i.data_gnt = 1'b1;
    tick();
    req_port_i = '0;
    tick();
    rst_ni = 1'b0;
    #1;
    check("t6_rst_req_port", req_port_o, 0);
    check("t6_rst_cmd_ready", cmd_ready_o, 1);
    check("t6_rst_rsp_valid", rsp_valid_o, 0);
    check("t6_rst_rsp_err", rsp_err_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("t6_no_rsp_after_rst", rsp_valid_o, 0);
    issue(1'b0, 56'h00_0000_0000_2018, 64'h0, 8'hFF);
    req_port_i.data_gnt = 1'b1;
    tick();
    req_port_i = '0;
    check("t6_tag_value", req_port_o.address_tag, 44'h2);
    tick();
    req_port_i.data_rvalid = 1'b1;
    req_port_i.data_rdata  = 64'h0123_4567_89AB_CDEF;
    tick();
    req_port_i = '0;
    check("t6_rsp_valid", rsp_valid_o, 1);
    check("t6_rsp_rdata", rsp_rdata_o, 64'h0123_4567_89AB_CDEF);
    check("t6_rsp_err", rsp_err_o, 0);
    tick();
    check("t6_idle_ready", cmd_ready_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
